// File: rtl/spi_shift_engine_pkg.sv
// Shared SPI mode constants and shift-engine FSM state encoding.
package spi_shift_engine_pkg;

  // {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-bit N-flop synchroniser; bit 0 additionally gets a lead/trail edge detector.
// Edge outputs are combinational from flops and valid the cycle the new level leaves the synchroniser.
module spi_sync_edge #(
  parameter int               WIDTH    = 1,
  parameter int               STAGES   = 2,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter bit               IDLE_LVL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync,
  output logic             o_lead,
  output logic             o_trail
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];
  logic             prev_q;
  logic             prev_d;

  always_comb begin
    sync_d[0] = i_async;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[STAGES-1][0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= RST_VAL;
      end
      prev_q <= RST_VAL[0];
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      prev_q <= prev_d;
    end
  end

  assign o_sync  = sync_q[STAGES-1];
  // Leading edge moves away from the idle level, trailing edge returns to it.
  assign o_lead  = (o_sync[0] != prev_q) && (o_sync[0] != IDLE_LVL);
  assign o_trail = (o_sync[0] != prev_q) && (o_sync[0] == IDLE_LVL);

endmodule

// File: rtl/spi_shift_engine.sv
// SPI slave bit engine: synchronises pins, deserialises MOSI into bytes, serialises TX onto MISO.
// byte_is_ready pulses one cycle after the last bit's sample edge; no backpressure, spi_cu must keep up.
module spi_shift_engine
  import spi_shift_engine_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_spi_sclk,
  input  logic                  i_spi_cs,
  input  logic                  i_spi_mosi,
  output logic                  o_spi_miso,
  output logic                  o_spi_miso_oe,
  output logic                  o_spi_cs_sync,
  input  logic                  i_shift_en,
  input  logic                  i_shift_reg_direction,
  input  logic                  i_shift_reg_par_load,
  input  logic [DATA_WIDTH-1:0] i_par_data,
  input  logic                  i_count_en,
  input  logic                  i_count_clr,
  output logic                  o_byte_is_ready,
  output logic [DATA_WIDTH-1:0] o_recieved_byte
);

  localparam int              CW             = $clog2(DATA_WIDTH);
  localparam logic [1:0]      SPI_MODE       = {CPOL, CPHA};
  localparam bit              SAMPLE_ON_LEAD = (SPI_MODE == MODE0) || (SPI_MODE == MODE2);
  localparam logic [CW-1:0]   LAST_BIT       = CW'(DATA_WIDTH - 1);

  logic [2:0] pins_s;
  logic       sclk_lead;
  logic       sclk_trail;
  logic       cs_s;
  logic       mosi_s;
  logic       sample_edge;
  logic       shift_edge;
  logic       active;
  logic       tx_shift;
  logic       byte_pulse;

  state_e                state_q,   state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] rx_q,      rx_d;
  logic [DATA_WIDTH-1:0] tx_q,      tx_d;
  logic [DATA_WIDTH-1:0] rbyte_q,   rbyte_d;
  logic                  rdy_q,     rdy_d;
  logic                  miso_q,    miso_d;
  logic                  tx_skip_q, tx_skip_d;

  spi_sync_edge #(
    .WIDTH    (3),
    .STAGES   (SYNC_STAGES),
    .RST_VAL  ({1'b0, 1'b1, CPOL}),
    .IDLE_LVL (CPOL)
  ) u_sync (
    .clk     (i_clk),
    .rst     (i_rst),
    .i_async ({i_spi_mosi, i_spi_cs, i_spi_sclk}),
    .o_sync  (pins_s),
    .o_lead  (sclk_lead),
    .o_trail (sclk_trail)
  );

  assign cs_s        = pins_s[1];
  assign mosi_s      = pins_s[2];
  assign sample_edge = SAMPLE_ON_LEAD ? sclk_lead  : sclk_trail;
  assign shift_edge  = SAMPLE_ON_LEAD ? sclk_trail : sclk_lead;
  assign active      = (state_q == ACTIVE) && !cs_s;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    byte_pulse = 1'b0;
    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        rx_d      = '0;
        if (!cs_s) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (cs_s) begin
          // Deselect mid-byte drops whatever was partially received.
          state_d   = IDLE;
          bit_cnt_d = '0;
          rx_d      = '0;
        end else if (sample_edge && i_shift_en) begin
          rx_d = i_shift_reg_direction ? {rx_q[DATA_WIDTH-2:0], mosi_s}
                                       : {mosi_s, rx_q[DATA_WIDTH-1:1]};
          if (i_count_en) begin
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d  = '0;
              byte_pulse = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (i_count_clr) begin
      bit_cnt_d  = '0;
      byte_pulse = 1'b0;
    end
    rdy_d   = byte_pulse;
    rbyte_d = byte_pulse ? rx_d : rbyte_q;
  end

  // With CPHA=1 the first shift edge after a load only presents bit 0, which is already on MISO.
  always_comb begin
    tx_shift  = active && shift_edge && i_shift_en;
    tx_d      = tx_q;
    tx_skip_d = tx_skip_q;
    if (i_shift_reg_par_load) begin
      tx_d      = i_par_data;
      tx_skip_d = 1'b1;
    end else if (tx_shift) begin
      if (CPHA && tx_skip_q) begin
        tx_skip_d = 1'b0;
      end else begin
        tx_d = i_shift_reg_direction ? {tx_q[DATA_WIDTH-2:0], 1'b0}
                                     : {1'b0, tx_q[DATA_WIDTH-1:1]};
      end
    end
    miso_d = i_shift_reg_direction ? tx_d[DATA_WIDTH-1] : tx_d[0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      rbyte_q   <= '0;
      rdy_q     <= 1'b0;
      miso_q    <= 1'b0;
      tx_skip_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      rbyte_q   <= rbyte_d;
      rdy_q     <= rdy_d;
      miso_q    <= miso_d;
      tx_skip_q <= tx_skip_d;
    end
  end

  assign o_spi_miso      = miso_q;
  assign o_spi_miso_oe   = !cs_s;
  assign o_spi_cs_sync   = cs_s;
  assign o_byte_is_ready = rdy_q;
  assign o_recieved_byte = rbyte_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed and random SPI master stimulus against one engine instance per SPI mode.
module tb_spi_shift_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, sclk_base, cs, mosi;
  logic       shift_en, dir, par_load, count_en, count_clr;
  logic [7:0] par_data;
  logic [3:0] miso, oe, cs_sync, rdy;
  logic [3:0][7:0] rbyte;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int cur     = 0;
  logic [7:0] got_q[$];
  int         got_cyc_q[$];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam bit POL = ((g / 2) % 2) == 1;
    localparam bit PHA = (g % 2) == 1;
    spi_shift_engine #(
      .DATA_WIDTH (8),
      .SYNC_STAGES(2),
      .CPOL       (POL),
      .CPHA       (PHA)
    ) u_dut (
      .i_clk                (clk),
      .i_rst                (rst),
      .i_spi_sclk           (sclk_base ^ POL),
      .i_spi_cs             (cs),
      .i_spi_mosi           (mosi),
      .o_spi_miso           (miso[g]),
      .o_spi_miso_oe        (oe[g]),
      .o_spi_cs_sync        (cs_sync[g]),
      .i_shift_en           (shift_en),
      .i_shift_reg_direction(dir),
      .i_shift_reg_par_load (par_load),
      .i_par_data           (par_data),
      .i_count_en           (count_en),
      .i_count_clr          (count_clr),
      .o_byte_is_ready      (rdy[g]),
      .o_recieved_byte      (rbyte[g])
    );
  end

  // Collect every byte the instance under test reports, with its cycle stamp.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rdy[cur]) begin
      got_q.push_back(rbyte[cur]);
      got_cyc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] d);
    par_data = d;
    par_load = 1'b1;
    wclk(1);
    par_load = 1'b0;
    wclk(3);
  endtask

  task automatic cs_low();
    cs = 1'b0;
    wclk(8);
  endtask

  task automatic cs_high();
    wclk(4);
    cs = 1'b1;
    wclk(8);
  endtask

  // Master side: SCLK = clk/8. 'seen' reassembles MISO bits at the bit positions they represent.
  task automatic send_bits(input int m, input logic [7:0] data, input int nbits,
                           input bit msb_first, input bit clr_last, output logic [7:0] seen);
    seen = '0;
    for (int i = 0; i < nbits; i++) begin
      int idx;
      idx = msb_first ? 7 - i : i;
      if (m % 2 == 0) begin
        mosi = data[idx];
        wclk(4);
        seen[idx] = miso[m];
        sclk_base = 1'b1;
        if (clr_last && i == nbits - 1) count_clr = 1'b1;
        wclk(4);
        count_clr = 1'b0;
        sclk_base = 1'b0;
      end else begin
        sclk_base = 1'b1;
        mosi = data[idx];
        wclk(4);
        seen[idx] = miso[m];
        sclk_base = 1'b0;
        wclk(4);
      end
    end
  endtask

  // One complete CS-framed byte: the slave should receive rxv and put tx on MISO in order.
  task automatic run_byte(input int m, input logic [7:0] tx, input logic [7:0] rxv,
                          input bit msb, input string tag);
    logic [7:0] seen;
    cur = m;
    dir = msb;
    got_q.delete();
    got_cyc_q.delete();
    load(tx);
    cs_low();
    chk({tag, "_oe_on"}, {31'd0, oe[m]}, 32'd1);
    send_bits(m, rxv, 8, msb, 1'b0, seen);
    cs_high();
    chk({tag, "_pulses"}, got_q.size(), 32'd1);
    chk({tag, "_rx"}, {24'd0, rbyte[m]}, {24'd0, rxv});
    chk({tag, "_miso"}, {24'd0, seen}, {24'd0, tx});
    chk({tag, "_oe_off"}, {31'd0, oe[m]}, 32'd0);
  endtask

  initial begin
    logic [7:0] seen;
    rst = 1'b1; cs = 1'b1; mosi = 1'b0; sclk_base = 1'b0;
    shift_en = 1'b1; count_en = 1'b1; count_clr = 1'b0;
    dir = 1'b1; par_load = 1'b0; par_data = '0;
    wclk(4);
    for (int g = 0; g < 4; g++) begin
      chk("rst_miso",   {31'd0, miso[g]},    32'd0);
      chk("rst_oe",     {31'd0, oe[g]},      32'd0);
      chk("rst_cssync", {31'd0, cs_sync[g]}, 32'd1);
      chk("rst_rdy",    {31'd0, rdy[g]},     32'd0);
      chk("rst_rbyte",  {24'd0, rbyte[g]},   32'd0);
    end
    rst = 1'b0;
    wclk(4);

    // Mode 0, MSB first: receive 0xA5 while 0x3C goes out.
    run_byte(0, 8'h3C, 8'hA5, 1'b1, "m0_msb");

    // LSB first, two back-to-back bytes in one frame.
    cur = 0; dir = 1'b0;
    got_q.delete(); got_cyc_q.delete();
    cs_low();
    send_bits(0, 8'h81, 8, 1'b0, 1'b0, seen);
    send_bits(0, 8'h0F, 8, 1'b0, 1'b0, seen);
    cs_high();
    chk("lsb_pulses", got_q.size(), 32'd2);
    if (got_q.size() == 2) begin
      chk("lsb_byte0", {24'd0, got_q[0]}, 32'h81);
      chk("lsb_byte1", {24'd0, got_q[1]}, 32'h0F);
      chk("lsb_gap", got_cyc_q[1] - got_cyc_q[0], 32'd64);
    end

    // Deselect after 5 bits: nothing reported, last byte retained, next byte clean.
    cur = 0; dir = 1'b1;
    got_q.delete(); got_cyc_q.delete();
    cs_low();
    send_bits(0, 8'hFF, 5, 1'b1, 1'b0, seen);
    cs_high();
    chk("partial_pulses", got_q.size(), 32'd0);
    chk("partial_hold", {24'd0, rbyte[0]}, 32'h0F);
    run_byte(0, 8'h00, 8'h5A, 1'b1, "after_partial");

    // count_clr on the 8th sample edge, then a full byte in the same frame.
    got_q.delete(); got_cyc_q.delete();
    cs_low();
    send_bits(0, 8'h33, 8, 1'b1, 1'b1, seen);
    chk("clr_no_pulse", got_q.size(), 32'd0);
    send_bits(0, 8'hE7, 8, 1'b1, 1'b0, seen);
    cs_high();
    chk("clr_pulses", got_q.size(), 32'd1);
    chk("clr_next_rx", {24'd0, rbyte[0]}, 32'hE7);

    // Reset after 3 bits, then a fresh byte.
    got_q.delete(); got_cyc_q.delete();
    cs_low();
    send_bits(0, 8'hFF, 3, 1'b1, 1'b0, seen);
    rst = 1'b1;
    wclk(2);
    chk("midrst_rbyte", {24'd0, rbyte[0]}, 32'd0);
    chk("midrst_cssync", {31'd0, cs_sync[0]}, 32'd1);
    rst = 1'b0;
    cs_high();
    chk("midrst_pulses", got_q.size(), 32'd0);
    run_byte(0, 8'h11, 8'hC3, 1'b1, "after_rst");

    // Remaining modes.
    run_byte(1, 8'h69, 8'h96, 1'b1, "mode1");
    run_byte(2, 8'h69, 8'h96, 1'b1, "mode2");
    run_byte(3, 8'h69, 8'h96, 1'b1, "mode3");

    // Random mode/direction/data.
    for (int k = 0; k < 8; k++) begin
      int m;
      logic [7:0] tx, rxv;
      bit msb;
      m   = $urandom_range(0, 3);
      msb = 1'($urandom_range(0, 1));
      tx  = 8'($urandom);
      rxv = 8'($urandom);
      run_byte(m, tx, rxv, msb, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
